decode_stage_module: RTL and testbench

//  Decode (ID) stage of the 5-stage RV32I pipeline, no hazard control. Consumes the fetch-stage outputs
//  (InstrD, PCD, PCPlus4D), owns the 32x32 register file (written by writeback), decodes control, sign-extends
//  the immediate, and registers everything into the ID/EX pipeline register feeding execute. Latency: 1 cycle.

---
 rtl/decode_stage_module.sv | 213 +++++++++++++++++++++
 tb/tb_decode_stage_module.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_module.sv
// RV32I decode stage: register file with write-through bypass, control and immediate decode,
// and the ID/EX pipeline register feeding execute.
module decode_stage_module #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           InstrD,
   input  logic [XLEN-1:0]       PCD,
   input  logic [XLEN-1:0]       PCPlus4D,
   input  logic                  RegWriteW,
   input  logic [REG_ADDR_W-1:0] RDW,
   input  logic [XLEN-1:0]       ResultW,
   output logic                  RegWriteE,
   output logic [1:0]            ResultSrcE,
   output logic                  MemWriteE,
   output logic                  JumpE,
   output logic                  BranchE,
   output logic                  ALUSrcE,
   output logic [2:0]            ALUControlE,
   output logic [XLEN-1:0]       RD1E,
   output logic [XLEN-1:0]       RD2E,
   output logic [XLEN-1:0]       ImmExtE,
   output logic [REG_ADDR_W-1:0] RDE,
   output logic [XLEN-1:0]       PCE,
   output logic [XLEN-1:0]       PCPlus4E
);

   localparam int NumRegs = 2 ** REG_ADDR_W;

   logic [XLEN-1:0] regFile [NumRegs];

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic                  funct7b5;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic [REG_ADDR_W-1:0] rd;

   logic            regWrite;
   logic [1:0]      immSrc;
   logic            aluSrc;
   logic            memWrite;
   logic [1:0]      resultSrc;
   logic            branch;
   logic [1:0]      aluOp;
   logic            jump;
   logic [2:0]      aluControl;
   logic [XLEN-1:0] immExt;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            wbActive;

   assign opcode   = InstrD[6:0];
   assign funct3   = InstrD[14:12];
   assign funct7b5 = InstrD[30];
   assign rs1      = InstrD[19:15];
   assign rs2      = InstrD[24:20];
   assign rd       = InstrD[11:7];
   assign wbActive = RegWriteW && (RDW != {REG_ADDR_W{1'b0}});

   // Register file storage; x0 is never written so it stays at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NumRegs; i++) begin
            regFile[i] <= {XLEN{1'b0}};
         end
      end else begin
         if (wbActive) begin
            regFile[RDW] <= ResultW;
         end
      end
   end

   // Operand read: x0 hard-wired to zero, same-cycle writeback forwarded to the reader.
   always_comb begin
      rd1 = {XLEN{1'b0}};
      rd2 = {XLEN{1'b0}};
      if (rs1 == {REG_ADDR_W{1'b0}}) begin
         rd1 = {XLEN{1'b0}};
      end else if (wbActive && (RDW == rs1)) begin
         rd1 = ResultW;
      end else begin
         rd1 = regFile[rs1];
      end
      if (rs2 == {REG_ADDR_W{1'b0}}) begin
         rd2 = {XLEN{1'b0}};
      end else if (wbActive && (RDW == rs2)) begin
         rd2 = ResultW;
      end else begin
         rd2 = regFile[rs2];
      end
   end

   // Main decoder; unknown opcodes become a bubble with every control low.
   always_comb begin
      regWrite  = 1'b0;
      immSrc    = 2'b00;
      aluSrc    = 1'b0;
      memWrite  = 1'b0;
      resultSrc = 2'b00;
      branch    = 1'b0;
      aluOp     = 2'b00;
      jump      = 1'b0;
      case (opcode)
         7'b0000011: begin
            regWrite  = 1'b1;
            aluSrc    = 1'b1;
            resultSrc = 2'b01;
         end
         7'b0100011: begin
            immSrc   = 2'b01;
            aluSrc   = 1'b1;
            memWrite = 1'b1;
         end
         7'b0110011: begin
            regWrite = 1'b1;
            aluOp    = 2'b10;
         end
         7'b1100011: begin
            immSrc = 2'b10;
            branch = 1'b1;
            aluOp  = 2'b01;
         end
         7'b0010011: begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
            aluOp    = 2'b10;
         end
         7'b1101111: begin
            regWrite  = 1'b1;
            immSrc    = 2'b11;
            resultSrc = 2'b10;
            jump      = 1'b1;
         end
         default: begin
            regWrite = 1'b0;
         end
      endcase
   end

   // ALU decoder; funct7[5] only selects sub for register-register ops, never for addi.
   always_comb begin
      aluControl = 3'b000;
      case (aluOp)
         2'b00: aluControl = 3'b000;
         2'b01: aluControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000: begin
                  if (opcode[5] && funct7b5) begin
                     aluControl = 3'b001;
                  end else begin
                     aluControl = 3'b000;
                  end
               end
               3'b010:  aluControl = 3'b101;
               3'b110:  aluControl = 3'b011;
               3'b111:  aluControl = 3'b010;
               default: aluControl = 3'b000;
            endcase
         end
         default: aluControl = 3'b000;
      endcase
   end

   // Immediate extension, sign taken from InstrD[31] in every format.
   always_comb begin
      immExt = {XLEN{1'b0}};
      case (immSrc)
         2'b00: immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
         2'b01: immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         2'b10: immExt = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         2'b11: immExt = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         default: immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      endcase
   end

   // ID/EX pipeline register; async reset holds every E output at zero while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteE   <= 1'b0;
         ResultSrcE  <= 2'b00;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= 3'b000;
         RD1E        <= {XLEN{1'b0}};
         RD2E        <= {XLEN{1'b0}};
         ImmExtE     <= {XLEN{1'b0}};
         RDE         <= {REG_ADDR_W{1'b0}};
         PCE         <= {XLEN{1'b0}};
         PCPlus4E    <= {XLEN{1'b0}};
      end else begin
         RegWriteE   <= regWrite;
         ResultSrcE  <= resultSrc;
         MemWriteE   <= memWrite;
         JumpE       <= jump;
         BranchE     <= branch;
         ALUSrcE     <= aluSrc;
         ALUControlE <= aluControl;
         RD1E        <= rd1;
         RD2E        <= rd2;
         ImmExtE     <= immExt;
         RDE         <= rd;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

endmodule

// File: tb/tb_decode_stage_module.sv
// Directed bench for decode_stage_module: hand-computed vectors checked with immediate assertions.
module tb_decode_stage_module;

   logic        clk;
   logic        rst;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        RegWriteW;
   logic [4:0]  RDW;
   logic [31:0] ResultW;
   logic        RegWriteE;
   logic [1:0]  ResultSrcE;
   logic        MemWriteE;
   logic        JumpE;
   logic        BranchE;
   logic        ALUSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic [31:0] ImmExtE;
   logic [4:0]  RDE;
   logic [31:0] PCE;
   logic [31:0] PCPlus4E;

   int checks;
   int failures;

   decode_stage_module dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
      .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step(input logic [31:0] instr, input logic [31:0] pc);
      InstrD   = instr;
      PCD      = pc;
      PCPlus4D = pc + 32'd4;
      @(posedge clk);
      #1;
   endtask

   task automatic checkCtrl(input string tag, input logic rw, input logic [1:0] rs, input logic mw,
                            input logic j, input logic b, input logic as, input logic [2:0] ac);
      check({tag, ".RegWriteE"}, {31'd0, RegWriteE}, {31'd0, rw});
      check({tag, ".ResultSrcE"}, {30'd0, ResultSrcE}, {30'd0, rs});
      check({tag, ".MemWriteE"}, {31'd0, MemWriteE}, {31'd0, mw});
      check({tag, ".JumpE"}, {31'd0, JumpE}, {31'd0, j});
      check({tag, ".BranchE"}, {31'd0, BranchE}, {31'd0, b});
      check({tag, ".ALUSrcE"}, {31'd0, ALUSrcE}, {31'd0, as});
      check({tag, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, ac});
   endtask

   task automatic checkAllZero(input string tag);
      checkCtrl(tag, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      check({tag, ".RD1E"}, RD1E, 32'd0);
      check({tag, ".RD2E"}, RD2E, 32'd0);
      check({tag, ".ImmExtE"}, ImmExtE, 32'd0);
      check({tag, ".RDE"}, {27'd0, RDE}, 32'd0);
      check({tag, ".PCE"}, PCE, 32'd0);
      check({tag, ".PCPlus4E"}, PCPlus4E, 32'd0);
   endtask

   initial begin
      logic [4:0] r;
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      InstrD    = 32'd0;
      PCD       = 32'd0;
      PCPlus4D  = 32'd0;
      RegWriteW = 1'b0;
      RDW       = 5'd0;
      ResultW   = 32'd0;

      InstrD = 32'h00500093;
      PCD    = 32'h0000_0040;
      @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b1;

      // addi x1,x0,5
      step(32'h00500093, 32'h0000_0100);
      checkCtrl("addi", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
      check("addi.ImmExtE", ImmExtE, 32'd5);
      check("addi.RDE", {27'd0, RDE}, 32'd1);
      check("addi.PCE", PCE, 32'h0000_0100);
      check("addi.PCPlus4E", PCPlus4E, 32'h0000_0104);

      // write x5 via writeback, then read it back from storage
      RegWriteW = 1'b1;
      RDW       = 5'd5;
      ResultW   = 32'h0000_0055;
      step({7'd0, 5'd5, 5'd5, 3'd0, 5'd0, 7'b0110011}, 32'h0000_0104);
      check("bypass_x5.RD1E", RD1E, 32'h0000_0055);
      RegWriteW = 1'b0;
      step({7'd0, 5'd5, 5'd5, 3'd0, 5'd0, 7'b0110011}, 32'h0000_0108);
      check("stored_x5.RD2E", RD2E, 32'h0000_0055);

      // jal x1,+16 so outputs are non-zero before the mid-stream reset
      step(32'h010000EF, 32'h0000_0200);
      checkCtrl("jal", 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
      check("jal.ImmExtE", ImmExtE, 32'h0000_0010);
      check("jal.RDE", {27'd0, RDE}, 32'd1);
      check("jal.PCE", PCE, 32'h0000_0200);
      check("jal.PCPlus4E", PCPlus4E, 32'h0000_0204);

      #2;
      rst = 1'b0;
      #1;
      checkAllZero("midreset");
      @(negedge clk);
      rst = 1'b1;

      // every register reads back zero after reset
      for (int i = 1; i < 32; i++) begin
         r = i[4:0];
         step({7'd0, r, r, 3'd0, 5'd0, 7'b0110011}, 32'h0000_0300);
         check($sformatf("rf_clear_x%0d.RD1E", i), RD1E, 32'd0);
         check($sformatf("rf_clear_x%0d.RD2E", i), RD2E, 32'd0);
      end

      // same-edge writeback and read of x2 (add x3,x2,x0)
      RegWriteW = 1'b1;
      RDW       = 5'd2;
      ResultW   = 32'hDEADBEEF;
      step(32'h000101B3, 32'h0000_0400);
      check("wb_bypass.RD1E", RD1E, 32'hDEADBEEF);
      check("wb_bypass.RD2E", RD2E, 32'd0);
      check("wb_bypass.RDE", {27'd0, RDE}, 32'd3);
      RegWriteW = 1'b0;
      step(32'h000101B3, 32'h0000_0404);
      check("wb_stored.RD1E", RD1E, 32'hDEADBEEF);

      // writes to x0 are ignored, also on the bypass path
      RegWriteW = 1'b1;
      RDW       = 5'd0;
      ResultW   = 32'h0000_1234;
      step(32'h00000033, 32'h0000_0408);
      check("x0_bypass.RD1E", RD1E, 32'd0);
      RegWriteW = 1'b0;
      step(32'h00000033, 32'h0000_040C);
      check("x0_read.RD1E", RD1E, 32'd0);
      check("x0_read.RD2E", RD2E, 32'd0);

      // beq x0,x0,-8
      step(32'hFE000CE3, 32'h0000_0500);
      checkCtrl("beq", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
      check("beq.ImmExtE", ImmExtE, 32'hFFFF_FFF8);

      // sw x5,8(x2): x2 still holds 0xDEADBEEF, x5 was cleared by reset
      step(32'h00512423, 32'h0000_0504);
      checkCtrl("sw", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
      check("sw.ImmExtE", ImmExtE, 32'd8);
      check("sw.RD1E", RD1E, 32'hDEADBEEF);
      check("sw.RD2E", RD2E, 32'd0);

      // lw x6,-4(x2)
      step({12'hFFC, 5'd2, 3'b010, 5'd6, 7'b0000011}, 32'h0000_0508);
      checkCtrl("lw", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
      check("lw.ImmExtE", ImmExtE, 32'hFFFF_FFFC);
      check("lw.RDE", {27'd0, RDE}, 32'd6);

      // sub x0,x1,x2
      step(32'h40208033, 32'h0000_050C);
      checkCtrl("sub", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);

      // funct7[5] set on an I-type add must still give add
      step({12'h400, 5'd1, 3'b000, 5'd4, 7'b0010011}, 32'h0000_0510);
      checkCtrl("addi_hi", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
      check("addi_hi.ImmExtE", ImmExtE, 32'h0000_0400);

      // slt, ori, andi, and an unlisted funct3 (xor -> add)
      step({7'd0, 5'd2, 5'd1, 3'b010, 5'd7, 7'b0110011}, 32'h0000_0514);
      check("slt.ALUControlE", {29'd0, ALUControlE}, 32'd5);
      step({12'hFFF, 5'd0, 3'b110, 5'd4, 7'b0010011}, 32'h0000_0518);
      check("ori.ALUControlE", {29'd0, ALUControlE}, 32'd3);
      check("ori.ImmExtE", ImmExtE, 32'hFFFF_FFFF);
      step({12'h0F0, 5'd0, 3'b111, 5'd4, 7'b0010011}, 32'h0000_051C);
      check("andi.ALUControlE", {29'd0, ALUControlE}, 32'd2);
      check("andi.ImmExtE", ImmExtE, 32'h0000_00F0);
      step({7'h20, 5'd2, 5'd1, 3'b100, 5'd7, 7'b0110011}, 32'h0000_0520);
      check("xor.ALUControlE", {29'd0, ALUControlE}, 32'd0);

      // unknown opcode 0x7F is a bubble on every control
      step(32'hFFFFFFFF, 32'h0000_0524);
      checkCtrl("op7f", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

      // InstrD=0 gives an all-zero bubble apart from the PC fields
      step(32'h00000000, 32'h0000_0528);
      checkCtrl("nop0", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      check("nop0.ImmExtE", ImmExtE, 32'd0);
      check("nop0.RDE", {27'd0, RDE}, 32'd0);
      check("nop0.RD1E", RD1E, 32'd0);
      check("nop0.PCE", PCE, 32'h0000_0528);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
